// File: rtl/axi_slv_pkg.sv
// rtl/axi_slv_pkg.sv - shared types for the AXI3 write-channel slave
package axi_slv_pkg;

  // FIFO entry widths; the slave's ADDR_W/ID_W parameters default to these.
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_fsm_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [3:0]            len;
    logic [2:0]            size;
    burst_e                burst;
  } aw_entry_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    resp_e               resp;
  } b_entry_t;

endpackage

// File: rtl/axi_slv_fifo.sv
// rtl/axi_slv_fifo.sv - synchronous FIFO with occupancy count for AW commands and B responses
module axi_slv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_slave.sv
// rtl/axi_wr_slave.sv - AXI3 write slave: AW/W to registered memory write port, one B per burst
// Optional WLAST/WID checking is compiled in with AXI_WR_PROTO_CHECK_EN.
module axi_wr_slave
  import axi_slv_pkg::*;
#(
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 4,
  parameter int ADDR_W   = AXI_ADDR_W,
  parameter int DATA_W   = 64,
  parameter int ID_W     = AXI_ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [ID_W-1:0]   AWID,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [ID_W-1:0]   WID,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam int AW_CW = $clog2(AW_DEPTH) + 1;
  localparam int B_CW  = $clog2(B_DEPTH) + 1;

  aw_entry_t             aw_in, aw_q;
  b_entry_t              b_in, b_q;
  logic [$bits(aw_entry_t)-1:0] aw_rdata;
  logic [$bits(b_entry_t)-1:0]  b_rdata;
  logic                  aw_push, aw_pop, aw_full, aw_empty;
  logic                  b_push, b_pop, b_full, b_empty;
  logic [AW_CW-1:0]      aw_count, aw_level_nxt;
  logic [B_CW-1:0]       b_count;
  logic                  aw_ready_q;

  wr_fsm_e               state, state_nxt;
  logic [3:0]            beat_cnt;
  logic [ADDR_W-1:0]     cur_addr, addr_nxt, addr_inc, wrap_mask;
  logic [2:0]            cur_size;
  burst_e                cur_burst;
  logic [ID_W-1:0]       cur_id;
  logic                  err, beat_err, last_beat, w_hs;
  logic                  unused_sigs;

  assign aw_in = '{addr: AXI_ADDR_W'(AWADDR), id: AXI_ID_W'(AWID), len: AWLEN,
                   size: AWSIZE, burst: burst_e'(AWBURST)};
  assign aw_q  = aw_entry_t'(aw_rdata);
  assign b_in  = '{id: AXI_ID_W'(cur_id), resp: (err ? RESP_SLVERR : RESP_OKAY)};
  assign b_q   = b_entry_t'(b_rdata);

  assign AWREADY = aw_ready_q;
  assign aw_push = AWVALID && aw_ready_q;
  assign BVALID  = !b_empty;
  assign BID     = ID_W'(b_q.id);
  assign BRESP   = b_q.resp;
  assign b_pop   = BVALID && BREADY;

  axi_slv_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk), .rst(rst), .push(aw_push), .push_data(aw_in), .pop(aw_pop),
    .pop_data(aw_rdata), .full(aw_full), .empty(aw_empty), .count(aw_count)
  );

  axi_slv_fifo #(.WIDTH($bits(b_entry_t)), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst), .push(b_push), .push_data(b_in), .pop(b_pop),
    .pop_data(b_rdata), .full(b_full), .empty(b_empty), .count(b_count)
  );

  // AWREADY is registered, so it is computed from the occupancy after this edge
  assign aw_level_nxt = aw_count + AW_CW'(aw_push) - AW_CW'(aw_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aw_ready_q <= 1'b0;
    else      aw_ready_q <= (aw_level_nxt < AW_CW'(AW_DEPTH));
  end

  assign last_beat = (beat_cnt == 4'd0);
  assign w_hs      = WVALID && WREADY;

`ifdef AXI_WR_PROTO_CHECK_EN
  assign beat_err    = (WLAST != last_beat) || (WID != cur_id);
  assign unused_sigs = ^{aw_full, b_count};
`else
  assign beat_err    = 1'b0;
  assign unused_sigs = ^{aw_full, b_count, WLAST, WID};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WR_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aw_pop    = 1'b0;
    b_push    = 1'b0;
    WREADY    = 1'b0;
    case (state)
      WR_IDLE: begin
        // only start a burst when its response is guaranteed a B slot
        if (!aw_empty && !b_full) begin
          aw_pop    = 1'b1;
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID && last_beat) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        b_push    = 1'b1;
        state_nxt = WR_IDLE;
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    addr_inc = ADDR_W'(1) << cur_size;
    case (cur_burst)
      BURST_FIXED: addr_nxt = cur_addr;
      BURST_WRAP:  addr_nxt = (cur_addr & ~wrap_mask) | ((cur_addr + addr_inc) & wrap_mask);
      default:     addr_nxt = cur_addr + addr_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt    <= '0;
      cur_addr    <= '0;
      cur_size    <= '0;
      cur_burst   <= BURST_FIXED;
      cur_id      <= '0;
      wrap_mask   <= '0;
      err         <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      if (aw_pop) begin
        beat_cnt  <= aw_q.len;
        cur_addr  <= ADDR_W'(aw_q.addr);
        cur_size  <= aw_q.size;
        cur_burst <= aw_q.burst;
        cur_id    <= ID_W'(aw_q.id);
        wrap_mask <= ((ADDR_W'(aw_q.len) + ADDR_W'(1)) << aw_q.size) - ADDR_W'(1);
        err       <= (aw_q.burst == BURST_RSVD);
      end else if (w_hs) begin
        mem_wr_en   <= !err && !beat_err;
        mem_wr_addr <= cur_addr;
        mem_wr_data <= WDATA;
        err         <= err || beat_err;
        if (!last_beat) begin
          beat_cnt <= beat_cnt - 4'd1;
          cur_addr <= addr_nxt;
        end
      end
    end
  end

endmodule
